// File: rtl/demux_1x4_stream.sv
// 1-to-4 valid/ready demultiplexer with a one-entry register per channel and a
// per-channel delivered-word counter; a stalled channel never blocks the others.

module demux_1x4_stream_lane #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_cnt
);
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // A load on the same edge as a drain overrides the clear, giving 1 word/cycle.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (vld_q && out_ready) begin
      vld_d = 1'b0;
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (load) begin
      vld_d  = 1'b1;
      data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_cnt   = cnt_q;
endmodule

module demux_1x4_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [1:0]          in_sel,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [4*DATA_W-1:0] out_data,
  output logic [4*CNT_W-1:0]  out_cnt
);
  localparam int NUM_CH = 4;

  logic [NUM_CH-1:0]             buf_valid;
  logic [NUM_CH-1:0]             load;
  logic [NUM_CH-1:0][DATA_W-1:0] buf_data;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt;

  // Only the selected channel's occupancy and consumer gate the producer.
  assign in_ready = ~buf_valid[in_sel] | out_ready[in_sel];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign load[k] = in_valid & in_ready & (in_sel == 2'(k));

    demux_1x4_stream_lane #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .in_data   (in_data),
      .out_ready (out_ready[k]),
      .out_valid (buf_valid[k]),
      .out_data  (buf_data[k]),
      .out_cnt   (cnt[k])
    );

    assign out_data[k*DATA_W +: DATA_W] = buf_data[k];
    assign out_cnt[k*CNT_W +: CNT_W]    = cnt[k];
  end

  assign out_valid = buf_valid;
endmodule

// File: doc/demux_1x4_stream.md
Name: demux_1x4_stream

Overview:
- Clocked 1-to-4 demultiplexer: the distribution-side counterpart of the 4:1 select mux.
- Routes one valid/ready input stream to one of four output channels, chosen per word by in_sel.
- Each channel has a one-entry output register, so a stalled channel does not block words headed to other channels.
- Sits between a single producer and four independent consumers. Also keeps a per-channel delivered-word counter for debug.

Parameters:
DATA_W, 8, width of each data word
CNT_W, 8, width of each per-channel delivered-word counter

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  producer has a word on in_data
in_ready  output  1  block accepts the word this cycle
in_data  input  DATA_W  input word
in_sel  input  2  destination channel 0..3 for in_data
out_valid  output  4  bit k: channel k holds a word
out_ready  input  4  bit k: consumer k takes the word this cycle
out_data  output  4*DATA_W  channel k word at bits [k*DATA_W +: DATA_W]
out_cnt  output  4*CNT_W  channel k delivered count at bits [k*CNT_W +: CNT_W]

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- While rst_n=0: out_valid=4'b0000, all out_data slices=0, all out_cnt slices=0.
  - in_ready is driven 1 (follows the formula below with all buffers empty).
  - No transfer is counted while rst_n=0.
- Per channel k, state is buf_valid[k] and buf_data[k]. out_valid[k]=buf_valid[k]; out_data slice k=buf_data[k], registered, with no combinational path from in_data.
- in_ready = ~buf_valid[in_sel] | out_ready[in_sel]. This is combinational from in_sel and out_ready[in_sel] only.
- Accept: in_valid & in_ready at a clock edge loads buf_data[in_sel]<=in_data and sets buf_valid[in_sel]. Latency is 1 cycle: out_valid rises the cycle after the accept.
- Drain: out_valid[k] & out_ready[k] at an edge is a delivery on channel k.
  - buf_valid[k] clears, unless a new accept to k happens at the same edge.
  - On simultaneous drain and accept on k, the new word replaces the old and valid stays 1. This gives full throughput of 1 word/cycle per channel.
- Stall: if buf_valid[in_sel]=1 and out_ready[in_sel]=0, then in_ready=0 and nothing is loaded.
- Channel independence: other channels keep draining normally during a stall.
- Producer rule: in_data must hold while in_valid=1 and in_ready=0. in_sel may change while stalled; in_ready is re-evaluated each cycle against the new in_sel.
- in_valid=0: no buffer changes except drains. out_ready on an empty channel has no effect.
- Counter: out_cnt slice k increments by 1 on every delivery on channel k. It wraps from 2^CNT_W-1 to 0 with no flag. Accepts do not count.
- Data is never duplicated, dropped or reordered within a channel. Ordering across channels is not guaranteed.
- Reset mid-operation: all held words are discarded immediately and counters go to 0. First accept is possible on the first edge after rst_n rises.

Test Plan:
- Reset: rst_n=0 with out_ready=4'hF, in_valid=1 -> out_valid=0, out_data=0, out_cnt=0, in_ready=1; no counter change.
- Basic routing: send 8'hA5,8'h3C,8'h81,8'h7E with in_sel=0,1,2,3 and out_ready=4'hF -> each out_valid[k] pulses 1 cycle after its accept with the matching data; every out_cnt slice =1.
- Stall/isolation: out_ready=4'b1011, send 8'h11 to ch2 then 8'h22 to ch2 -> in_ready=0 on the second word; 8'h11 is held on ch2.
  - Meanwhile 8'h33 to ch0 is accepted and delivered.
  - Raising out_ready[2] delivers 8'h11 then 8'h22, and out_cnt ch2 =2.
- Back-to-back throughput: 16 consecutive words to ch1 with out_ready[1]=1 -> in_ready stays 1, one word per cycle in order, out_cnt ch1=16.
- Counter wrap: 256 deliveries on ch3 -> out_cnt ch3 returns to 0; 257th delivery gives 1.
- Reset mid-operation: ch0 and ch2 full and stalled, assert rst_n=0 between edges -> out_valid drops to 0 immediately and counters clear. After release, 8'h5A to ch2 appears 1 cycle later.
